// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W);
    return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
           (f3 == LSU_BU) || (f3 == LSU_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  is_store;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] store_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  // master is the surrounding environment (execute stage + memory)
  modport master (
    output req_valid, is_store, funct3, addr, store_data, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, is_store, funct3, addr, store_data, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store strobes/replication, load extraction and extension.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            offset_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            wstrb_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] load_o,
  output logic                  misaligned_o
);
  logic [DATA_WIDTH-1:0] lane;

  always_comb begin
    lane         = rdata_i >> {offset_i, 3'b000};
    wstrb_o      = 4'b0000;
    wdata_o      = store_data_i;
    load_o       = '0;
    misaligned_o = 1'b0;

    // funct3[1:0] is the access size for both loads and stores
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_o = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        wstrb_o      = 4'b0011 << offset_i;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = offset_i[0];
      end
      2'b10: begin
        wstrb_o      = 4'b1111;
        misaligned_o = (offset_i != 2'b00);
      end
      default: ;
    endcase

    case (funct3_i)
      LSU_B:   load_o = {{24{lane[7]}}, lane[7:0]};
      LSU_H:   load_o = {{16{lane[15]}}, lane[15:0]};
      LSU_W:   load_o = rdata_i;
      LSU_BU:  load_o = {24'd0, lane[7:0]};
      LSU_HU:  load_o = {16'd0, lane[15:0]};
      default: load_o = '0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/ACCESS/RESP FSM around one req/ack memory access.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);
  lsu_state_e            state_q, state_d;
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_wstrb_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic                  accept_ok, accept_err, capture;
  logic [2:0]            al_funct3;
  logic [1:0]            al_offset;
  logic [3:0]            al_wstrb;
  logic [DATA_WIDTH-1:0] al_wdata, al_load;
  logic                  al_misaligned;

  // In IDLE the aligner sees the incoming request; afterwards the latched one
  assign al_funct3 = (state_q == LSU_IDLE) ? bus.funct3    : funct3_q;
  assign al_offset = (state_q == LSU_IDLE) ? bus.addr[1:0] : offset_q;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3_i     (al_funct3),
    .offset_i     (al_offset),
    .store_data_i (bus.store_data),
    .rdata_i      (bus.mem_rdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .load_o       (al_load),
    .misaligned_o (al_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    accept_ok  = 1'b0;
    accept_err = 1'b0;
    capture    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (bus.req_valid) begin
          if (funct3_legal(bus.is_store, bus.funct3) && !al_misaligned) begin
            accept_ok = 1'b1;
            state_d   = LSU_ACCESS;
          end else begin
            accept_err = 1'b1;
            state_d    = LSU_RESP;
          end
        end
      end
      LSU_ACCESS: begin
        if (bus.mem_ack) begin
          capture = 1'b1;
          state_d = LSU_RESP;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_ok || accept_err) begin
        is_store_q <= bus.is_store;
        funct3_q   <= bus.funct3;
        offset_q   <= bus.addr[1:0];
      end
      if (accept_ok) begin
        mem_we_q    <= bus.is_store;
        mem_addr_q  <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wstrb_q <= bus.is_store ? al_wstrb : 4'b0000;
        mem_wdata_q <= al_wdata;
      end
      if (accept_err) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
      if (capture) begin
        rsp_data_q <= is_store_q ? '0 : al_load;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign bus.req_ready = (state_q == LSU_IDLE);
  assign bus.mem_req   = (state_q == LSU_ACCESS);
  assign bus.rsp_valid = (state_q == LSU_RESP);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, corner sequences, random ops vs byte-level model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  localparam logic [31:0] BASE = 32'h0000_0100;
  logic [7:0]  ref_mem [64];
  logic [31:0] mem_w   [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v  = 0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 1);
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s;
    s = 0;
    for (int i = 0; i < size_of(f3); i++) s[(a % 4) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8 * j +: 8] = d[8 * (j % size_of(f3)) +: 8];
    return w;
  endfunction

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int waits, input bit use_rd,
                        input logic [31:0] rd, output logic err_o, output logic [31:0] data_o,
                        output int lat, output bit saw_req, output logic we_o,
                        output logic [3:0] strb_o, output logic [31:0] wdata_o,
                        output logic [31:0] addr_o);
    int guard, waited, w;
    bit done;
    err_o = 1'bx; data_o = 'x; lat = 0; saw_req = 0;
    we_o = 1'bx; strb_o = 'x; wdata_o = 'x; addr_o = 'x;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    if (!bus.req_ready) chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.store_data = d;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; waited = 0; done = 0;
    while (!done && lat < 40) begin
      if (bus.rsp_valid) begin
        err_o = bus.rsp_err; data_o = bus.rsp_data; done = 1;
      end else begin
        if (bus.mem_req) begin
          saw_req = 1;
          if (waited >= waits) begin
            we_o = bus.mem_we; strb_o = bus.mem_wstrb;
            wdata_o = bus.mem_wdata; addr_o = bus.mem_addr;
            if (use_rd) bus.mem_rdata = rd;
            else begin
              w = int'((bus.mem_addr - BASE) >> 2);
              if (w >= 0 && w < 16) begin
                if (bus.mem_we)
                  for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) mem_w[w][8 * b +: 8] = bus.mem_wdata[8 * b +: 8];
                bus.mem_rdata = mem_w[w];
              end else bus.mem_rdata = 32'hBAD0_BAD0;
            end
            bus.mem_ack = 1'b1;
          end else waited++;
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        lat++;
      end
    end
    if (!done) chk("rsp_timeout", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, d, rd;
    int          waits;
    logic        e_err;
    logic [31:0] e_data;
    int          e_lat;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vt [15];

  initial begin : main
    logic        g_err, g_we;
    logic [31:0] g_data, g_wdata, g_addr, stored, e_load;
    logic [3:0]  g_strb;
    int          g_lat, rv_cnt;
    bit          g_req, legal;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, d;
    int          waits, off;

    vt[0]  = '{1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 0, 1'b0, 32'h0, 2, 4'b1000, 32'hA5A5_A5A5};
    vt[1]  = '{1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000_8000, 2, 1'b0, 32'hFFFF_FF80, 4, 4'b0000, 32'h0};
    vt[2]  = '{1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000_8000, 2, 1'b0, 32'h0000_0080, 4, 4'b0000, 32'h0};
    vt[3]  = '{1'b0, 3'b001, 32'h3002, 32'h0, 32'h7FFF_1234, 0, 1'b0, 32'h0000_7FFF, 2, 4'b0000, 32'h0};
    vt[4]  = '{1'b0, 3'b010, 32'h3002, 32'h0, 32'h7FFF_1234, 0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
    vt[5]  = '{1'b0, 3'b011, 32'h0000, 32'h0, 32'h1111_1111, 0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
    vt[6]  = '{1'b1, 3'b001, 32'h5002, 32'h1234_ABCD, 32'h0, 1, 1'b0, 32'h0, 3, 4'b1100, 32'hABCD_ABCD};
    vt[7]  = '{1'b1, 3'b010, 32'h6000, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 32'h0, 2, 4'b1111, 32'hDEAD_BEEF};
    vt[8]  = '{1'b1, 3'b100, 32'h7000, 32'h5555_5555, 32'h0, 0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
    vt[9]  = '{1'b0, 3'b101, 32'h7002, 32'h0, 32'h8001_1234, 0, 1'b0, 32'h0000_8001, 2, 4'b0000, 32'h0};
    vt[10] = '{1'b0, 3'b001, 32'h7002, 32'h0, 32'h8001_1234, 0, 1'b0, 32'hFFFF_8001, 2, 4'b0000, 32'h0};
    vt[11] = '{1'b0, 3'b000, 32'h8003, 32'h0, 32'h7F00_0000, 3, 1'b0, 32'h0000_007F, 5, 4'b0000, 32'h0};
    vt[12] = '{1'b1, 3'b001, 32'h9001, 32'hFFFF_FFFF, 32'h0, 0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
    vt[13] = '{1'b1, 3'b010, 32'h9002, 32'hFFFF_FFFF, 32'h0, 0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
    vt[14] = '{1'b0, 3'b010, 32'hA000, 32'h0, 32'h89AB_CDEF, 1, 1'b0, 32'h89AB_CDEF, 3, 4'b0000, 32'h0};

    for (int b = 0; b < 64; b++) ref_mem[b] = 8'($urandom);
    for (int w = 0; w < 16; w++)
      mem_w[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

    rst = 1'b1;
    bus.req_valid = 0; bus.is_store = 0; bus.funct3 = 0; bus.addr = 0;
    bus.store_data = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  bus.mem_addr,       32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  bus.rsp_data,       32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].st, vt[i].f3, vt[i].a, vt[i].d, vt[i].waits, 1'b1, vt[i].rd,
             g_err, g_data, g_lat, g_req, g_we, g_strb, g_wdata, g_addr);
      chk($sformatf("vec%0d_err", i),  32'(g_err),  32'(vt[i].e_err));
      chk($sformatf("vec%0d_data", i), g_data,      vt[i].e_data);
      chk($sformatf("vec%0d_lat", i),  32'(g_lat),  32'(vt[i].e_lat));
      chk($sformatf("vec%0d_memreq", i), 32'(g_req), 32'(!vt[i].e_err));
      if (!vt[i].e_err) begin
        chk($sformatf("vec%0d_addr", i), g_addr, vt[i].a & 32'hFFFF_FFFC);
        chk($sformatf("vec%0d_we", i),   32'(g_we),   32'(vt[i].st));
        chk($sformatf("vec%0d_strb", i), 32'(g_strb), 32'(vt[i].e_strb));
        if (vt[i].st) chk($sformatf("vec%0d_wdata", i), g_wdata, vt[i].e_wdata);
      end
    end

    // response fields hold after the pulse
    @(posedge clk); #1;
    chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("hold_rsp_data",  bus.rsp_data, 32'h89AB_CDEF);

    // reset in the second ACCESS cycle with ack withheld, then a late ack
    bus.is_store = 0; bus.funct3 = LSU_W; bus.addr = BASE; bus.req_valid = 1;
    @(posedge clk); #1; bus.req_valid = 0;
    chk("rstmid_memreq_c1", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    chk("rstmid_memreq_c2", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1; rst = 1'b0;
    chk("rstmid_memreq_after", 32'(bus.mem_req), 32'd0);
    chk("rstmid_ready_after",  32'(bus.req_ready), 32'd1);
    bus.mem_rdata = 32'h1234_5678; bus.mem_ack = 1;
    rv_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; bus.mem_ack = 0;
      if (bus.rsp_valid || bus.mem_req) rv_cnt++;
    end
    chk("rstmid_late_ack", 32'(rv_cnt), 32'd0);

    // reset beats a simultaneous request
    bus.req_valid = 1; rst = 1;
    @(posedge clk); #1; rst = 0; bus.req_valid = 0;
    chk("rstprio_memreq", 32'(bus.mem_req), 32'd0);
    chk("rstprio_ready",  32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rstprio_memreq2", 32'(bus.mem_req), 32'd0);
    chk("rstprio_rspv",    32'(bus.rsp_valid), 32'd0);

    // SW then LW back to back with req_valid held high
    bus.is_store = 1; bus.funct3 = LSU_W; bus.addr = 32'h4000;
    bus.store_data = 32'hCAFE_F00D; bus.req_valid = 1;
    @(posedge clk); #1;
    bus.is_store = 0; bus.store_data = 0;
    chk("b2b_c1_ready", 32'(bus.req_ready), 32'd0);
    chk("b2b_c1_memreq", 32'(bus.mem_req), 32'd1);
    chk("b2b_c1_we", 32'(bus.mem_we), 32'd1);
    stored = bus.mem_wdata; bus.mem_ack = 1;
    @(posedge clk); #1; bus.mem_ack = 0;
    chk("b2b_c2_rspv", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_c2_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b2b_c3_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1; bus.req_valid = 0;
    chk("b2b_c4_memreq", 32'(bus.mem_req), 32'd1);
    chk("b2b_c4_we", 32'(bus.mem_we), 32'd0);
    chk("b2b_c4_addr", bus.mem_addr, 32'h4000);
    bus.mem_rdata = stored; bus.mem_ack = 1;
    @(posedge clk); #1; bus.mem_ack = 0;
    chk("b2b_c5_rspv", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_c5_data", bus.rsp_data, 32'hCAFE_F00D);

    // random ops against the byte-addressed reference memory
    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom); f3 = 3'($urandom_range(0, 7));
      off = $urandom_range(0, 63); a = BASE + 32'(off);
      d = $urandom; waits = $urandom_range(0, 3);
      legal = ref_legal(st, f3, a);
      e_load = (legal && !st) ? ref_load(f3, off) : 32'd0;
      run_op(st, f3, a, d, waits, 1'b0, 32'd0,
             g_err, g_data, g_lat, g_req, g_we, g_strb, g_wdata, g_addr);
      chk("rnd_err",  32'(g_err), 32'(!legal));
      chk("rnd_data", g_data, e_load);
      chk("rnd_lat",  32'(g_lat), legal ? 32'(2 + waits) : 32'd1);
      chk("rnd_memreq", 32'(g_req), 32'(legal));
      if (legal) begin
        chk("rnd_addr", g_addr, a & 32'hFFFF_FFFC);
        chk("rnd_we",   32'(g_we), 32'(st));
        chk("rnd_strb", 32'(g_strb), st ? 32'(ref_strb(f3, a)) : 32'd0);
        if (st) begin
          chk("rnd_wdata", g_wdata, ref_wdata(f3, d));
          for (int i = 0; i < size_of(f3); i++) ref_mem[off + i] = d[8 * i +: 8];
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle RV32I load/store unit sitting directly downstream of the registered ALU: it takes the ALU result as the effective address, performs one data-memory access over a simple req/ack bus, and returns the load value or completion to writeback. It handles byte/halfword/word alignment, byte strobes, and sign/zero extension. Misaligned addresses and illegal funct3 codes are flagged without touching memory.

## Interface
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width code: loads LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
- addr  in  ADDR_WIDTH  effective address, i.e. the ALU result.
- store_data  in  DATA_WIDTH  rs2 value.
- mem_req  out  1  memory access request, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  word-aligned address, with addr[1:0] forced to 00.
- mem_wstrb  out  4  byte write strobes.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_ack  in  1  memory completes the access this cycle.
- mem_rdata  in  DATA_WIDTH  read word, valid when mem_ack=1.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_WIDTH  extended load value; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid; misaligned address or illegal funct3.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch is_store, funct3, addr and store_data.
  - If the request is legal, go to ACCESS; otherwise set the err flag and go to RESP.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_wstrb and mem_wdata are driven from registers and stay stable.
  - On mem_ack, capture the extended load result and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Illegal requests:
  - Illegal funct3: load 011/110/111, or store with funct3 other than 000/001/010.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00.
- Store lanes, with o = addr[1:0]:
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<o.
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<o.
  - SW: wdata=d, wstrb=1111.
- Load extraction: take lane = mem_rdata>>(8*o).
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- During loads: mem_wstrb=0000, mem_we=0.
- mem_ack is ignored outside ACCESS.

## Timing
- Reset values: state=IDLE, req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- Accept at edge E0. mem_req rises at E0 and is visible in cycle 1.
- Zero-wait ack in cycle 1 gives rsp_valid in cycle 2. Next acceptance is possible in cycle 3, so minimum request-to-request spacing is 3 cycles.
- Each wait cycle (mem_ack=0 in ACCESS) adds one cycle. No timeout.
- Error path: accept at E0, rsp_valid/rsp_err in cycle 1, mem_req never asserted.
- rsp_data and rsp_err hold their value until the next response; only rsp_valid pulses.
- rst mid-ACCESS: next edge forces IDLE and mem_req=0. A late mem_ack after reset is ignored.
- rst has priority over req_valid and mem_ack in the same cycle.
- req_valid while not in IDLE is not accepted. The upstream stage holds it until req_ready.

## Structure
- Add to defines.v: `LSU_B/`LSU_H/`LSU_W/`LSU_BU/`LSU_HU funct3 codes and FSM state encodings `LSU_IDLE/`LSU_ACCESS/`LSU_RESP (2 bits).
- One combinational sub-module, lsu_align. It maps funct3, offset, store_data and rdata to wstrb, wdata, load result and misaligned. The top holds the FSM and registers.

## Test plan
- SB at addr 0x1003 with data 0x000000A5, zero-wait ack: mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, rsp_valid in cycle 2, rsp_err=0.
- LB at 0x2001, rdata=0x0000_8000 after 2 wait cycles: rsp_data=0xFFFFFF80 in cycle 4. LBU with the same stimulus gives 0x00000080.
- LH at 0x3002, rdata=0x7FFF_1234: rsp_data=0x00007FFF. LW at 0x3002: rsp_err=1, rsp_data=0, mem_req never asserted, rsp_valid in cycle 1.
- Load with funct3=011 at 0x0: rsp_err=1, no memory access.
- rst asserted in cycle 2 of an ACCESS with ack withheld: mem_req=0 from the next cycle, req_ready=1, a later mem_ack produces no rsp_valid.
- Back-to-back SW 0x4000 then LW 0x4000 with req_valid held high: second acceptance occurs in cycle 3, and the LW returns the value supplied by the memory model.
